bpc_dbp_unpack: RTL and testbench
=================================

Name: bpc_dbp_unpack

Overview:
- Parametrised back end for the BPC decompressor: takes decoded DBX symbols from the decoder group (up to LANES per cycle) and rebuilds bit planes with the XOR chain.
- Transposes the planes into deltas and reconstructs the original words.
- Streams the words out OUT_WORDS per beat under valid/ready.
- Adds ping-pong plane banks, so one block fills while the previous one drains, plus base-relative or chained delta mode, early end-of-block, and error flagging.

Parameters:
- WORD_W, 16, word/delta width and the number of bit planes per block.
- NUM_WORDS, 64, words per block; each plane is NUM_WORDS-1 bits.
- OUT_WORDS, 4, words per output beat; NUM_WORDS % OUT_WORDS must be 0.
- LANES, 4, DBX symbols accepted per cycle.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- sym_valid_i, input, LANES, per-lane symbol valid; must be contiguous from lane 0.
- sym_data_i, input, LANES*(NUM_WORDS-1), DBX symbols; lane 0 is in the MSBs.
- sym_xor_i, input, LANES, per-lane "XOR with previous plane" flag.
- sym_sop_i, input, 1, lane 0 is plane 0 of a new block.
- sym_base_i, input, WORD_W, base word; sampled on an sop accept.
- sym_mode_i, input, 1, 0 = base-relative, 1 = chained; sampled on an sop accept.
- sym_eob_i, input, 1, block ends after this cycle's lanes; remaining planes are zero.
- sym_ready_o, output, 1, fill bank can accept symbols.
- out_valid_o, output, 1, beat valid.
- out_ready_i, input, 1, downstream ready.
- out_data_o, output, OUT_WORDS*WORD_W, words; lowest word index is in the MSBs.
- out_sop_o, output, 1, first beat of a block.
- out_eop_o, output, 1, last beat of a block.
- err_o, output, 1, one-cycle protocol-error pulse.

Behaviour:
- State:
  - 2 banks, each holding WORD_W planes, base, mode and a full flag.
  - fill_ptr, drain_ptr, plane_cnt (0..WORD_W), beat_cnt (0..NUM_WORDS/OUT_WORDS-1), chain accumulator.
- Reset: all flags, pointers, counters and planes are 0. Outputs: sym_ready_o=1, out_valid_o=0, out_sop_o=0, out_eop_o=0, err_o=0, out_data_o=0. Reset mid-block or mid-drain discards everything.
- Accept rule:
  - sym_ready_o = !full[fill_ptr].
  - Lane n is accepted when sym_valid_i[n] & sym_ready_o.
  - Lane n is written to plane plane_cnt+n.
- XOR chain:
  - Plane 0 = symbol; the flag is ignored.
  - Plane p>0 = xor ? (symbol ^ plane p-1) : symbol.
  - Plane p-1 may come from an earlier lane in the same cycle; this chain is combinational.
- sop:
  - Lane 0 is plane 0; base and mode are captured; plane_cnt restarts.
  - If plane_cnt != 0 when sop arrives: the partial block is discarded, err_o pulses, and the new block starts.
  - Accepted lanes with no sop while plane_cnt==0 are dropped and err_o pulses.
- Block completion, when plane_cnt reaches WORD_W or an eob is accepted:
  - Unfilled planes are forced to 0.
  - full[fill_ptr] is set and fill_ptr toggles at that edge; plane_cnt is set to 0.
  - Lanes beyond plane WORD_W-1 are dropped and err_o pulses.
- Transpose: delta[k] bit (WORD_W-1-p) = plane p bit (NUM_WORDS-2-k).
- Reconstruction, all arithmetic mod 2^WORD_W (wraps silently):
  - Word 0 = base in both modes.
  - Base mode: word k = base + delta[k-1].
  - Chained mode: word k = word k-1 + delta[k-1]; the accumulator carries across beats.
- Output:
  - out_valid_o = full[drain_ptr], combinational from the flag.
  - Latency: the final plane is accepted at edge t; out_valid_o is high in the cycle after edge t.
  - Beat b carries words b*OUT_WORDS .. b*OUT_WORDS+OUT_WORDS-1.
  - out_sop_o = valid & (beat_cnt==0); out_eop_o = valid & (beat_cnt==last).
  - A beat advances when out_valid_o & out_ready_i.
  - Data is held stable while out_ready_i=0.
- Drain completion:
  - On accept of the eop beat: full[drain_ptr] clears, drain_ptr toggles, beat_cnt is set to 0.
  - The freed bank is visible as sym_ready_o in the next cycle.
  - Filling one bank and draining the other in the same cycle is legal; back-to-back blocks give no output bubble.
- Both banks full: sym_ready_o=0 and symbols are held upstream, never dropped.

Test Plan (WORD_W=16, NUM_WORDS=64, OUT_WORDS=4, LANES=4):
- All-zero planes, base 0x1234, mode 0, out_ready_i=1 -> 16 beats of 0x1234123412341234; sop on beat 0, eop on beat 15; out_valid_o high in the cycle after edge t.
- Plane 15 all ones, others 0, base 0x0010:
  - Mode 0 -> beat 0 = 0x0010001100110011.
  - Mode 1 -> beat 0 = 0x0010001100120013, beat 15 = 0x004C004D004E004F.
- Plane 0 all ones, plane 1 all ones with xor=1, base 0 -> plane 1 = 0, all deltas 0x8000, beat 0 = 0x0000800080008000; base 0xFFFF with plane 15 ones, mode 0 -> words 1..63 = 0x0000 (wrap).
- out_ready_i=0, push two full blocks -> sym_ready_o falls after the 2nd block completes. Raise out_ready_i -> 32 consecutive beats, and sym_ready_o rises the cycle after the first eop accept.
- sop with 2 lanes + eob, planes 0 and 1 all ones, base 0 -> planes 2..15 are zero, words 1..63 = 0xC000.
- sop at plane_cnt=5 -> err_o pulses once, the new block completes normally. rst_n low mid-drain -> out_valid_o=0, sym_ready_o=1 immediately.

Source files
------------

// File: rtl/bpc_dbp_unpack.sv
// bpc_dbp_unpack
//   Back end of the BPC decompressor. It takes decoded DBX symbols (up to
//   LANES per cycle), rebuilds the bit planes through the XOR chain, and stores
//   them in one of two ping-pong banks. It then transposes the planes of the
//   draining bank into deltas and streams the reconstructed words out.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   sym_valid_i        per-lane symbol valid, contiguous from lane 0
//   sym_data_i         LANES symbols of NUM_WORDS-1 bits, lane 0 in the MSBs
//   sym_xor_i          per-lane "XOR with previous plane" flag
//   sym_sop_i          lane 0 carries plane 0 of a new block
//   sym_base_i/mode_i  base word and delta mode (0 base, 1 chained), taken on sop
//   sym_eob_i          block ends after this cycle's lanes
//   sym_ready_o        fill bank can take symbols
//   out_valid_o/ready  output beat handshake
//   out_data_o         OUT_WORDS words, lowest word index in the MSBs
//   out_sop_o/eop_o    first / last beat of a block
//   err_o              one-cycle protocol-error pulse
module bpc_dbp_unpack #(
    parameter int WORD_W    = 16,
    parameter int NUM_WORDS = 64,
    parameter int OUT_WORDS = 4,
    parameter int LANES     = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [LANES-1:0]                  sym_valid_i,
    input  logic [LANES*(NUM_WORDS-1)-1:0]    sym_data_i,
    input  logic [LANES-1:0]                  sym_xor_i,
    input  logic                              sym_sop_i,
    input  logic [WORD_W-1:0]                 sym_base_i,
    input  logic                              sym_mode_i,
    input  logic                              sym_eob_i,
    output logic                              sym_ready_o,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [OUT_WORDS*WORD_W-1:0]       out_data_o,
    output logic                              out_sop_o,
    output logic                              out_eop_o,
    output logic                              err_o
);

    localparam int PW  = NUM_WORDS - 1;
    localparam int NB  = NUM_WORDS / OUT_WORDS;
    localparam int CW  = $clog2(WORD_W + 1);
    localparam int PIW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int BIW = (PW > 1) ? $clog2(PW) : 1;
    localparam int BW  = (NB > 1) ? $clog2(NB) : 1;

    logic [1:0][WORD_W-1:0][PW-1:0] planes_q, planes_d;
    logic [1:0][WORD_W-1:0]         base_q, base_d;
    logic [1:0]                     mode_q, mode_d;
    logic [1:0]                     full_q, full_d;
    logic                           fill_ptr_q, fill_ptr_d;
    logic                           drain_ptr_q, drain_ptr_d;
    logic [CW-1:0]                  plane_cnt_q, plane_cnt_d;
    logic [BW-1:0]                  beat_cnt_q, beat_cnt_d;
    logic [WORD_W-1:0]              acc_q, acc_d;
    logic                           err_q, err_d;

    logic [OUT_WORDS*WORD_W-1:0]    out_words;
    logic                           beat_fire;

    assign sym_ready_o = !full_q[fill_ptr_q];
    assign out_valid_o = full_q[drain_ptr_q];
    assign out_data_o  = out_valid_o ? out_words : '0;
    assign out_sop_o   = out_valid_o & (beat_cnt_q == '0);
    assign out_eop_o   = out_valid_o & (beat_cnt_q == BW'(NB - 1));
    assign err_o       = err_q;
    assign beat_fire   = out_valid_o & out_ready_i;

    // Word reconstruction for the current beat. 'run' walks the chained sum
    // across the beat; acc_q holds the last word of the previous beat.
    always_comb begin : recon
        logic [WORD_W-1:0] run;
        logic [WORD_W-1:0] w;
        logic [WORD_W-1:0] delta;
        int                k;
        out_words = '0;
        run       = acc_q;
        for (int j = 0; j < OUT_WORDS; j++) begin
            k     = int'(beat_cnt_q) * OUT_WORDS + j;
            delta = '0;
            if (k == 0) begin
                w = base_q[drain_ptr_q];
            end else begin
                // delta[k-1] bit (WORD_W-1-p) lives in plane p bit (PW-k)
                for (int p = 0; p < WORD_W; p++)
                    delta[WORD_W-1-p] = planes_q[drain_ptr_q][p][BIW'(PW - k)];
                w = mode_q[drain_ptr_q] ? (run + delta) : (base_q[drain_ptr_q] + delta);
            end
            run = w;
            out_words[(OUT_WORDS-1-j)*WORD_W +: WORD_W] = w;
        end
    end

    always_comb begin : next_state
        logic [LANES-1:0] acc_lane;
        logic             active;
        logic [PW-1:0]    prev;
        logic [PW-1:0]    sym;
        logic [PW-1:0]    val;
        int               start;
        int               idx;
        int               cnt;

        planes_d    = planes_q;
        base_d      = base_q;
        mode_d      = mode_q;
        full_d      = full_q;
        fill_ptr_d  = fill_ptr_q;
        drain_ptr_d = drain_ptr_q;
        plane_cnt_d = plane_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        acc_d       = acc_q;
        err_d       = 1'b0;

        acc_lane = sym_valid_i & {LANES{sym_ready_o}};
        active   = 1'b0;
        start    = 0;
        prev     = '0;
        sym      = '0;
        val      = '0;
        idx      = 0;
        cnt      = 0;

        // ---- fill side ----
        if (|acc_lane) begin
            if (sym_sop_i) begin
                // A new block restarts the bank; clearing it here also makes
                // planes never written (early eob) read back as zero.
                if (plane_cnt_q != '0) err_d = 1'b1;
                planes_d[fill_ptr_q] = '0;
                base_d[fill_ptr_q]   = sym_base_i;
                mode_d[fill_ptr_q]   = sym_mode_i;
                active = 1'b1;
            end else if (plane_cnt_q == '0) begin
                err_d = 1'b1;                     // stray lanes outside a block
            end else begin
                start  = int'(plane_cnt_q);
                prev   = planes_q[fill_ptr_q][PIW'(start - 1)];
                active = 1'b1;
            end

            if (active) begin
                cnt = start;
                // Lanes chain combinationally: each lane XORs against the
                // plane produced by the lane before it.
                for (int n = 0; n < LANES; n++) begin
                    if (acc_lane[n]) begin
                        idx = start + n;
                        if (idx < WORD_W) begin
                            sym = sym_data_i[(LANES-n)*PW-1 -: PW];
                            val = (idx != 0 && sym_xor_i[n]) ? (sym ^ prev) : sym;
                            planes_d[fill_ptr_q][PIW'(idx)] = val;
                            prev = val;
                            cnt  = idx + 1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                if (cnt >= WORD_W || sym_eob_i) begin
                    full_d[fill_ptr_q] = 1'b1;
                    fill_ptr_d         = ~fill_ptr_q;
                    plane_cnt_d        = '0;
                end else begin
                    plane_cnt_d = CW'(cnt);
                end
            end
        end

        // ---- drain side (always the other bank from any fill completion) ----
        if (beat_fire) begin
            acc_d = out_words[WORD_W-1:0];
            if (beat_cnt_q == BW'(NB - 1)) begin
                full_d[drain_ptr_q] = 1'b0;
                drain_ptr_d         = ~drain_ptr_q;
                beat_cnt_d          = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            planes_q    <= '0;
            base_q      <= '0;
            mode_q      <= '0;
            full_q      <= '0;
            fill_ptr_q  <= 1'b0;
            drain_ptr_q <= 1'b0;
            plane_cnt_q <= '0;
            beat_cnt_q  <= '0;
            acc_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            planes_q    <= planes_d;
            base_q      <= base_d;
            mode_q      <= mode_d;
            full_q      <= full_d;
            fill_ptr_q  <= fill_ptr_d;
            drain_ptr_q <= drain_ptr_d;
            plane_cnt_q <= plane_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            acc_q       <= acc_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_bpc_dbp_unpack.sv
// Scoreboard bench for bpc_dbp_unpack: a block model turns each pushed block
// of symbols into expected beats; the output monitor pops and compares.
module tb_bpc_dbp_unpack;

    localparam int WORD_W    = 16;
    localparam int NUM_WORDS = 64;
    localparam int OUT_WORDS = 4;
    localparam int LANES     = 4;
    localparam int PW        = NUM_WORDS - 1;
    localparam int NB        = NUM_WORDS / OUT_WORDS;

    typedef struct packed {
        logic [OUT_WORDS*WORD_W-1:0] data;
        logic                        sop;
        logic                        eop;
    } beat_t;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic [LANES-1:0]             sym_valid_i;
    logic [LANES*PW-1:0]          sym_data_i;
    logic [LANES-1:0]             sym_xor_i;
    logic                         sym_sop_i;
    logic [WORD_W-1:0]            sym_base_i;
    logic                         sym_mode_i;
    logic                         sym_eob_i;
    logic                         sym_ready_o;
    logic                         out_valid_o;
    logic                         out_ready_i;
    logic [OUT_WORDS*WORD_W-1:0]  out_data_o;
    logic                         out_sop_o;
    logic                         out_eop_o;
    logic                         err_o;

    bpc_dbp_unpack #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS),
                     .OUT_WORDS(OUT_WORDS), .LANES(LANES)) dut (
        .clk(clk), .rst_n(rst_n),
        .sym_valid_i(sym_valid_i), .sym_data_i(sym_data_i), .sym_xor_i(sym_xor_i),
        .sym_sop_i(sym_sop_i), .sym_base_i(sym_base_i), .sym_mode_i(sym_mode_i),
        .sym_eob_i(sym_eob_i), .sym_ready_o(sym_ready_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_sop_o(out_sop_o), .out_eop_o(out_eop_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            err_cnt = 0;
    beat_t         sb[$];
    beat_t         mon_e;
    logic [63:0]   first_beat, last_beat;
    logic [PW-1:0] sym_tab [WORD_W];
    logic          xor_tab [WORD_W];
    logic          lat_chk = 1'b0;
    logic          rnd_rdy = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp_v);
        end
    endtask

    // Output monitor / scoreboard pop.
    always @(negedge clk) begin
        if (rst_n) begin
            if (err_o) err_cnt++;
            if (out_valid_o && out_ready_i) begin
                if (sb.size() == 0) chk("unexp_beat", 64'd1, 64'd0);
                else begin
                    mon_e = sb.pop_front();
                    chk("beat_data", out_data_o, mon_e.data);
                    chk("beat_sop", {63'd0, out_sop_o}, {63'd0, mon_e.sop});
                    chk("beat_eop", {63'd0, out_eop_o}, {63'd0, mon_e.eop});
                end
                if (out_sop_o) first_beat = out_data_o;
                if (out_eop_o) last_beat  = out_data_o;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_rdy) out_ready_i = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // Block model: XOR chain, zero fill after np planes, transpose, rebuild.
    task automatic push_exp(input int np, input logic [WORD_W-1:0] base, input logic mode);
        logic [PW-1:0]     pl [WORD_W];
        logic [WORD_W-1:0] w  [NUM_WORDS];
        logic [WORD_W-1:0] d;
        beat_t             e;
        for (int p = 0; p < WORD_W; p++) begin
            if (p >= np)                   pl[p] = '0;
            else if (p > 0 && xor_tab[p]) pl[p] = sym_tab[p] ^ pl[p-1];
            else                           pl[p] = sym_tab[p];
        end
        w[0] = base;
        for (int k = 1; k < NUM_WORDS; k++) begin
            for (int p = 0; p < WORD_W; p++) d[WORD_W-1-p] = pl[p][NUM_WORDS-2-(k-1)];
            w[k] = mode ? w[k-1] + d : base + d;
        end
        for (int b = 0; b < NB; b++) begin
            for (int j = 0; j < OUT_WORDS; j++)
                e.data[(OUT_WORDS-1-j)*WORD_W +: WORD_W] = w[b*OUT_WORDS+j];
            e.sop = (b == 0);
            e.eop = (b == NB - 1);
            sb.push_back(e);
        end
    endtask

    task automatic idle_in();
        sym_valid_i = '0; sym_data_i = '0; sym_xor_i = '0;
        sym_sop_i = 0; sym_eob_i = 0;
    endtask

    task automatic wait_rdy();
        int g = 0;
        while (!sym_ready_o && g < 2000) begin @(posedge clk); #1; g++; end
        if (!sym_ready_o) chk("rdy_timeout", {63'd0, sym_ready_o}, 64'd1);
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((sb.size() != 0 || out_valid_o) && g < 3000) begin @(posedge clk); #1; g++; end
        chk("drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic clear_tab();
        for (int p = 0; p < WORD_W; p++) begin sym_tab[p] = '0; xor_tab[p] = 0; end
    endtask

    // Drive n lanes from sym_tab[0..n-1] in one cycle.
    task automatic drive_cyc(input int n, input logic sop, input logic eob);
        wait_rdy();
        idle_in();
        for (int l = 0; l < n; l++) begin
            sym_valid_i[l] = 1'b1;
            sym_data_i[(LANES-l)*PW-1 -: PW] = sym_tab[l];
        end
        sym_sop_i = sop; sym_eob_i = eob;
        @(posedge clk); #1;
        idle_in();
    endtask

    task automatic send_block(input int np, input logic [WORD_W-1:0] base,
                              input logic mode, input int lpc);
        int p = 0;
        int n;
        push_exp(np, base, mode);
        while (p < np) begin
            n = (np - p < lpc) ? np - p : lpc;
            wait_rdy();
            idle_in();
            for (int l = 0; l < n; l++) begin
                sym_valid_i[l] = 1'b1;
                sym_data_i[(LANES-l)*PW-1 -: PW] = sym_tab[p+l];
                sym_xor_i[l] = xor_tab[p+l];
            end
            sym_sop_i  = (p == 0);
            sym_base_i = base;
            sym_mode_i = mode;
            sym_eob_i  = (p + n == np) && (np < WORD_W);
            if (lat_chk && p + n == np) chk("lat_pre", {63'd0, out_valid_o}, 64'd0);
            @(posedge clk); #1;
            if (lat_chk && p + n == np) chk("lat_post", {63'd0, out_valid_o}, 64'd1);
            idle_in();
            p += n;
        end
    endtask

    initial begin
        int e0;
        idle_in();
        sym_base_i = '0; sym_mode_i = 0; out_ready_i = 1'b1;
        rst_n = 1'b0;
        #23;
        chk("rst_ready", {63'd0, sym_ready_o}, 64'd1);
        chk("rst_valid", {63'd0, out_valid_o}, 64'd0);
        chk("rst_sop",   {63'd0, out_sop_o},   64'd0);
        chk("rst_eop",   {63'd0, out_eop_o},   64'd0);
        chk("rst_err",   {63'd0, err_o},       64'd0);
        chk("rst_data",  out_data_o,           64'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // All-zero planes, base mode, latency check.
        clear_tab();
        lat_chk = 1'b1;
        send_block(16, 16'h1234, 1'b0, 4);
        lat_chk = 1'b0;
        wait_drain();
        chk("zero_first", first_beat, 64'h1234123412341234);
        chk("zero_last",  last_beat,  64'h1234123412341234);

        // Plane 15 all ones.
        clear_tab(); sym_tab[15] = '1;
        send_block(16, 16'h0010, 1'b0, 4);
        wait_drain();
        chk("p15_base_b0", first_beat, 64'h0010001100110011);
        send_block(16, 16'h0010, 1'b1, 4);
        wait_drain();
        chk("p15_chain_b0",  first_beat, 64'h0010001100120013);
        chk("p15_chain_b15", last_beat,  64'h004C004D004E004F);

        // XOR chain inside one cycle.
        clear_tab(); sym_tab[0] = '1; sym_tab[1] = '1; xor_tab[1] = 1;
        send_block(16, 16'h0000, 1'b0, 4);
        wait_drain();
        chk("xor_b0", first_beat, 64'h0000800080008000);

        // Wrap-around.
        clear_tab(); sym_tab[15] = '1;
        send_block(16, 16'hFFFF, 1'b0, 4);
        wait_drain();
        chk("wrap_b0",  first_beat, 64'hFFFF000000000000);
        chk("wrap_b15", last_beat,  64'h0000000000000000);

        // Early eob after two planes.
        clear_tab(); sym_tab[0] = '1; sym_tab[1] = '1;
        send_block(2, 16'h0000, 1'b0, 2);
        wait_drain();
        chk("eob_b0",  first_beat, 64'h0000C000C000C000);
        chk("eob_b15", last_beat,  64'hC000C000C000C000);

        // Backpressure: both banks fill, then drain back to back.
        out_ready_i = 1'b0;
        clear_tab(); sym_tab[15] = '1;
        send_block(16, 16'h0100, 1'b0, 4);
        send_block(16, 16'h0200, 1'b1, 4);
        chk("bp_ready_low", {63'd0, sym_ready_o}, 64'd0);
        @(posedge clk); #1;
        chk("bp_ready_hold", {63'd0, sym_ready_o}, 64'd0);
        out_ready_i = 1'b1;
        for (int i = 0; i < 2 * NB; i++) begin
            @(negedge clk);
            chk("bp_b2b_valid", {63'd0, out_valid_o}, 64'd1);
            if (i == NB - 1) chk("bp_ready_pre", {63'd0, sym_ready_o}, 64'd0);
            if (i == NB)     chk("bp_ready_post", {63'd0, sym_ready_o}, 64'd1);
        end
        @(posedge clk); #1;
        wait_drain();

        // sop while a block is in progress.
        e0 = err_cnt;
        clear_tab(); sym_tab[0] = '1; sym_tab[3] = '1;
        drive_cyc(4, 1'b1, 1'b0);
        drive_cyc(1, 1'b0, 1'b0);
        clear_tab(); sym_tab[2] = '1; sym_tab[9] = '1; xor_tab[9] = 1;
        send_block(16, 16'h0777, 1'b1, 4);
        wait_drain();
        chk("sop_restart_err", 64'(err_cnt - e0), 64'd1);

        // Stray lane outside a block.
        e0 = err_cnt;
        drive_cyc(1, 1'b0, 1'b0);
        repeat (3) @(posedge clk); #1;
        chk("stray_err", 64'(err_cnt - e0), 64'd1);
        chk("stray_no_out", {63'd0, out_valid_o}, 64'd0);

        // Randomised blocks with random backpressure.
        rnd_rdy = 1'b1;
        for (int b = 0; b < 6; b++) begin
            for (int p = 0; p < WORD_W; p++) begin
                sym_tab[p] = PW'({$urandom(), $urandom()});
                xor_tab[p] = 1'($urandom_range(0, 1));
            end
            send_block($urandom_range(1, 16), 16'($urandom()), 1'($urandom_range(0, 1)),
                       $urandom_range(1, 4));
        end
        wait_drain();
        rnd_rdy = 1'b0;
        @(posedge clk); #2;
        out_ready_i = 1'b1;

        // Reset in the middle of a drain.
        out_ready_i = 1'b0;
        clear_tab(); sym_tab[15] = '1;
        send_block(16, 16'h4321, 1'b0, 4);
        chk("mid_valid_pre", {63'd0, out_valid_o}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, out_valid_o}, 64'd0);
        chk("mid_rst_ready", {63'd0, sym_ready_o}, 64'd1);
        sb.delete();
        @(posedge clk); #1; rst_n = 1'b1; out_ready_i = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("post_rst_valid", {63'd0, out_valid_o}, 64'd0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
